// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, mid-bit sampling.
// A completed frame is held on the outputs until the consumer acknowledges it.
module uart_rx #(
    parameter int clk_frequency = 27,
    parameter int baud_rate     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_byte_accept,
    input  logic       i_data_bit,
    output logic       o_done,
    output logic [7:0] o_data_byte,
    output logic       parity_error,
    output logic       framing_error
);

    localparam int DATA_W = 8;
    localparam int CPB    = (clk_frequency * 1_000_000) / baud_rate;
    localparam int HALF   = CPB / 2;
    localparam int CNT_W  = ($clog2(CPB) > 16) ? $clog2(CPB) : 16;

    localparam logic [CNT_W-1:0] CPB_END  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic               sync_p0;
    logic               sync_p1;
    logic [DATA_W-1:0]  shift;
    logic               par_bad;
    logic               cnt_end;

    function automatic logic parity_of(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

    // Stage p0/p1: two-flop synchronizer, idles high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= i_data_bit;
            sync_p1 <= sync_p0;
        end
    end

    assign cnt_end = (cnt == CPB_END);

    always_ff @(posedge clk) begin
        if (state == DATA && cnt_end)
            shift <= {sync_p1, shift[DATA_W-1:1]};
        if (state == PARITY && cnt_end)
            par_bad <= sync_p1 ^ parity_of(shift);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            o_done        <= 1'b0;
            o_data_byte   <= 8'h00;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!sync_p1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    // Half a bit in: a high line here means the low was only a glitch.
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        state <= sync_p1 ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7)
                            state <= PARITY;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_end) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_end) begin
                        cnt           <= '0;
                        framing_error <= ~sync_p1;
                        parity_error  <= par_bad;
                        o_data_byte   <= shift;
                        o_done        <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (i_byte_accept) begin
                        o_done <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of directed frames, hand-written corner sequences,
// and random frames checked against a parity/stop-bit reference model.
module tb_uart_rx;

    localparam int CPB  = (27 * 1_000_000) / 115200;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_byte_accept = 1'b0;
    logic       i_data_bit = 1'b1;
    logic       o_done;
    logic [7:0] o_data_byte;
    logic       parity_error;
    logic       framing_error;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t tbl[6];

    uart_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_byte_accept (i_byte_accept),
        .i_data_bit    (i_data_bit),
        .o_done        (o_done),
        .o_data_byte   (o_data_byte),
        .parity_error  (parity_error),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: data is the byte itself; the parity flag is set when the count of ones
    // over data plus parity bit is odd; the framing flag is set when the stop bit is low.
    task automatic model(input logic [7:0] d, input logic p, input logic s,
                         output logic [7:0] ed, output logic epe, output logic efe);
        int ones;
        ones = $countones(d) + (p ? 1 : 0);
        ed  = d;
        epe = (ones % 2) != 0;
        efe = !s;
    endtask

    // Drives one frame; start_len lets a frame begin part-way into its start bit.
    // rise reports the cycle within the stop bit at which o_done rose (-1 if it did not).
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int start_len, input bit mid_ack, output int rise);
        logic was_done;
        was_done = o_done;
        rise = -1;
        i_data_bit = 1'b0;
        hold(start_len);
        for (int i = 0; i < 8; i++) begin
            i_data_bit = d[i];
            if (mid_ack && i == 3) begin
                hold(10);
                i_byte_accept = 1'b1;
                hold(1);
                i_byte_accept = 1'b0;
                hold(CPB - 11);
            end else begin
                hold(CPB);
            end
        end
        i_data_bit = p;
        hold(CPB);
        i_data_bit = s;
        for (int k = 1; k <= CPB; k++) begin
            @(posedge clk);
            #1;
            if (rise < 0 && o_done && !was_done) rise = k;
        end
    endtask

    task automatic check_frame(input string tag, input int rise, input logic [7:0] ed,
                               input logic epe, input logic efe);
        checks++;
        if (rise < HALF || rise > HALF + 3) begin
            failures++;
            $display("FAIL %s_done_latency: rose at cycle %0d of stop bit, required %0d..%0d",
                     tag, rise, HALF, HALF + 3);
        end
        chk({tag, "_done"}, 32'(o_done), 32'd1);
        chk({tag, "_data"}, 32'(o_data_byte), 32'(ed));
        chk({tag, "_parity_error"}, 32'(parity_error), 32'(epe));
        chk({tag, "_framing_error"}, 32'(framing_error), 32'(efe));
    endtask

    task automatic ack_and_check(input string tag, input logic [7:0] ed,
                                 input logic epe, input logic efe);
        i_byte_accept = 1'b1;
        hold(1);
        i_byte_accept = 1'b0;
        chk({tag, "_done_after_ack"}, 32'(o_done), 32'd0);
        chk({tag, "_data_retained"}, 32'(o_data_byte), 32'(ed));
        chk({tag, "_flags_retained"}, 32'({parity_error, framing_error}), 32'({epe, efe}));
    endtask

    initial begin
        logic [7:0] ed;
        logic       epe, efe, p, s;
        logic [7:0] d;
        bit         mack;
        int         rise;

        tbl[0] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[2] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        tbl[3] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        tbl[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[5] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 1'b1};

        // Reset state, with inputs wiggling while reset is held.
        hold(3);
        i_data_bit = 1'b0;
        i_byte_accept = 1'b1;
        hold(3);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_data", 32'(o_data_byte), 32'h00);
        chk("reset_flags", 32'({parity_error, framing_error}), 32'd0);
        i_data_bit = 1'b1;
        i_byte_accept = 1'b0;
        hold(4);
        rst_n = 1'b0;
        hold(10);
        chk("idle_done", 32'(o_done), 32'd0);

        for (int v = 0; v < 6; v++) begin
            send_frame(tbl[v].data, tbl[v].par, tbl[v].stop, CPB, 1'b0, rise);
            i_data_bit = 1'b1;
            check_frame($sformatf("tbl%0d", v), rise, tbl[v].exp_data, tbl[v].exp_pe, tbl[v].exp_fe);
            hold(5);
            ack_and_check($sformatf("tbl%0d", v), tbl[v].exp_data, tbl[v].exp_pe, tbl[v].exp_fe);
            hold(20);
        end

        // Short low glitch is rejected, then a good frame follows.
        i_data_bit = 1'b0;
        hold(50);
        i_data_bit = 1'b1;
        hold(300);
        chk("glitch_no_done", 32'(o_done), 32'd0);
        send_frame(8'h3C, 1'b0, 1'b1, CPB, 1'b0, rise);
        check_frame("after_glitch", rise, 8'h3C, 1'b0, 1'b0);
        ack_and_check("after_glitch", 8'h3C, 1'b0, 1'b0);
        hold(20);

        // Back-to-back frames without ack: the second is lost.
        send_frame(8'h11, 1'b0, 1'b1, CPB, 1'b0, rise);
        check_frame("b2b_first", rise, 8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, CPB, 1'b0, rise);
        chk("b2b_done_held", 32'(o_done), 32'd1);
        chk("b2b_data_held", 32'(o_data_byte), 32'h11);
        ack_and_check("b2b", 8'h11, 1'b0, 1'b0);
        hold(20);
        send_frame(8'h33, 1'b0, 1'b1, CPB, 1'b0, rise);
        check_frame("b2b_next", rise, 8'h33, 1'b0, 1'b0);
        ack_and_check("b2b_next", 8'h33, 1'b0, 1'b0);
        hold(20);

        // Low stop bit, acked while the line stays low: that low is a new start bit.
        send_frame(8'h96, 1'b0, 1'b0, CPB, 1'b0, rise);
        check_frame("low_stop", rise, 8'h96, 1'b0, 1'b1);
        ack_and_check("low_stop", 8'h96, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1, CPB - 2, 1'b0, rise);
        check_frame("restart_from_low", rise, 8'hC3, 1'b0, 1'b0);
        ack_and_check("restart_from_low", 8'hC3, 1'b0, 1'b0);
        hold(20);

        // Reset in the middle of DATA for 0xFF aborts it; 0x81 then arrives cleanly.
        i_data_bit = 1'b0;
        hold(CPB);
        i_data_bit = 1'b1;
        hold(3 * CPB + 50);
        rst_n = 1'b1;
        #1;
        chk("midreset_data_cleared", 32'(o_data_byte), 32'h00);
        chk("midreset_done", 32'(o_done), 32'd0);
        i_byte_accept = 1'b1;
        hold(4);
        i_byte_accept = 1'b0;
        chk("midreset_flags", 32'({parity_error, framing_error}), 32'd0);
        rst_n = 1'b0;
        hold(3 * CPB);
        chk("midreset_no_resume", 32'(o_done), 32'd0);
        send_frame(8'h81, 1'b0, 1'b1, CPB, 1'b0, rise);
        check_frame("after_reset", rise, 8'h81, 1'b0, 1'b0);
        ack_and_check("after_reset", 8'h81, 1'b0, 1'b0);
        hold(20);

        // Random frames with occasional parity/stop errors and stray acks mid-frame.
        for (int r = 0; r < 8; r++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            s = ($urandom_range(0, 3) != 0);
            mack = bit'($urandom_range(0, 1));
            model(d, p, s, ed, epe, efe);
            send_frame(d, p, s, CPB, mack, rise);
            i_data_bit = 1'b1;
            check_frame($sformatf("rand%0d", r), rise, ed, epe, efe);
            hold(3);
            ack_and_check($sformatf("rand%0d", r), ed, epe, efe);
            hold($urandom_range(5, 40));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
